// File: rtl/alu_operand_collector.sv
// Operand collector ahead of the ALU: merges split-operand host commands, enforces
// a timeout on the missing operand and stalls the host while a multiply is in flight.
module alu_operand_collector #(
  parameter int unsigned n       = 8,
  parameter int unsigned m       = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned MUL_GAP = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         MODE,
  input  logic [m-1:0] CMD,
  input  logic [1:0]   INP_VALID,
  input  logic [n-1:0] OPA,
  input  logic [n-1:0] OPB,
  input  logic         CIN,
  output logic         BUSY,
  output logic         TIMEOUT_ERR,
  output logic         ALU_CE,
  output logic         ALU_MODE,
  output logic [m-1:0] ALU_CMD,
  output logic         ALU_CIN,
  output logic [1:0]   ALU_INP_VALID,
  output logic [n-1:0] ALU_OPA,
  output logic [n-1:0] ALU_OPB
);

  localparam int unsigned CW = $clog2(TIMEOUT + MUL_GAP + 1) + 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] M_LAST = CW'(MUL_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           l_mode, l_mode_n, l_cin, l_cin_n;
  logic [m-1:0]   l_cmd, l_cmd_n;
  logic [1:0]     l_iv, l_iv_n;
  logic [n-1:0]   l_opa, l_opa_n, l_opb, l_opb_n;
  logic           err_n, ce_n, mode_n, cin_n;
  logic [m-1:0]   cmd_n;
  logic [1:0]     iv_n;
  logic [n-1:0]   opa_n, opb_n;
  logic           iss;

  function automatic logic two_op(input logic md, input logic [m-1:0] c);
    int unsigned ci;
    ci = 32'(c);
    if (md) return (ci <= 3) || (ci >= 8 && ci <= 12);
    else    return (ci <= 5) || (ci == 12) || (ci == 13);
  endfunction

  assign BUSY = (state == S_HOLD);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    l_mode_n = l_mode;
    l_cmd_n  = l_cmd;
    l_cin_n  = l_cin;
    l_iv_n   = l_iv;
    l_opa_n  = l_opa;
    l_opb_n  = l_opb;
    err_n    = 1'b0;
    ce_n     = 1'b0;
    mode_n   = ALU_MODE;
    cmd_n    = ALU_CMD;
    cin_n    = ALU_CIN;
    iv_n     = ALU_INP_VALID;
    opa_n    = ALU_OPA;
    opb_n    = ALU_OPB;
    iss      = 1'b0;
    case (state)
      S_IDLE: begin
        if (CE && INP_VALID != 2'b00) begin
          if (two_op(MODE, CMD) && INP_VALID != 2'b11) begin
            l_mode_n = MODE;
            l_cmd_n  = CMD;
            l_cin_n  = CIN;
            l_iv_n   = INP_VALID;
            l_opa_n  = OPA;
            l_opb_n  = OPB;
            cnt_n    = '0;
            state_n  = S_WAIT;
          end else begin
            iss    = 1'b1;
            mode_n = MODE;
            cmd_n  = CMD;
            cin_n  = CIN;
            iv_n   = INP_VALID;
            opa_n  = OPA;
            opb_n  = OPB;
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt + 1'b1;
        // An arriving operand takes priority over expiry on the same edge.
        if (CE && (INP_VALID & ~l_iv) != 2'b00) begin
          iss    = 1'b1;
          mode_n = l_mode;
          cmd_n  = l_cmd;
          cin_n  = l_cin;
          iv_n   = 2'b11;
          opa_n  = l_iv[0] ? l_opa : OPA;
          opb_n  = l_iv[1] ? l_opb : OPB;
        end else if (cnt == T_LAST) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_HOLD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == M_LAST) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (iss) begin
      ce_n = 1'b1;
      if (mode_n && (32'(cmd_n) == 9 || 32'(cmd_n) == 10)) begin
        state_n = S_HOLD;
        cnt_n   = '0;
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= S_IDLE;
      cnt           <= '0;
      l_mode        <= 1'b0;
      l_cmd         <= '0;
      l_cin         <= 1'b0;
      l_iv          <= '0;
      l_opa         <= '0;
      l_opb         <= '0;
      TIMEOUT_ERR   <= 1'b0;
      ALU_CE        <= 1'b0;
      ALU_MODE      <= 1'b0;
      ALU_CMD       <= '0;
      ALU_CIN       <= 1'b0;
      ALU_INP_VALID <= '0;
      ALU_OPA       <= '0;
      ALU_OPB       <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      l_mode        <= l_mode_n;
      l_cmd         <= l_cmd_n;
      l_cin         <= l_cin_n;
      l_iv          <= l_iv_n;
      l_opa         <= l_opa_n;
      l_opb         <= l_opb_n;
      TIMEOUT_ERR   <= err_n;
      ALU_CE        <= ce_n;
      ALU_MODE      <= mode_n;
      ALU_CMD       <= cmd_n;
      ALU_CIN       <= cin_n;
      ALU_INP_VALID <= iv_n;
      ALU_OPA       <= opa_n;
      ALU_OPB       <= opb_n;
    end
  end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Bench for alu_operand_collector: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_alu_operand_collector;

  localparam int unsigned TO  = 16;
  localparam int unsigned GAP = 3;

  logic       CLK = 1'b0;
  logic       RST, CE, MODE, CIN;
  logic [3:0] CMD;
  logic [1:0] INP_VALID;
  logic [7:0] OPA, OPB;
  logic       BUSY, TIMEOUT_ERR, ALU_CE, ALU_MODE, ALU_CIN;
  logic [3:0] ALU_CMD;
  logic [1:0] ALU_INP_VALID;
  logic [7:0] ALU_OPA, ALU_OPB;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_busy_left, m_age;
  bit         m_pend;
  logic [1:0] m_held;
  logic       m_mode, m_cin;
  logic [3:0] m_cmd;
  logic [7:0] m_opa, m_opb;
  logic       e_busy, e_err, e_ce, e_mode, e_cin;
  logic [3:0] e_cmd;
  logic [1:0] e_iv;
  logic [7:0] e_opa, e_opb;

  alu_operand_collector #(.n(8), .m(4), .TIMEOUT(TO), .MUL_GAP(GAP)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR),
    .ALU_CE(ALU_CE), .ALU_MODE(ALU_MODE), .ALU_CMD(ALU_CMD), .ALU_CIN(ALU_CIN),
    .ALU_INP_VALID(ALU_INP_VALID), .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit needs_two(input logic md, input logic [3:0] c);
    int unsigned ci;
    ci = c;
    return md ? (ci inside {0, 1, 2, 3, 8, 9, 10, 11, 12})
              : (ci inside {0, 1, 2, 3, 4, 5, 12, 13});
  endfunction

  task automatic model_issue(input logic md, input logic [3:0] c, input logic ci,
                             input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b);
    e_ce = 1; e_mode = md; e_cmd = c; e_cin = ci; e_iv = iv; e_opa = a; e_opb = b;
    if (md && (c == 4'd9 || c == 4'd10)) m_busy_left = GAP;
  endtask

  task automatic model_step();
    e_ce = 0; e_err = 0;
    if (!RST) begin
      m_busy_left = 0; m_pend = 0; m_age = 0;
      e_mode = 0; e_cmd = 0; e_cin = 0; e_iv = 0; e_opa = 0; e_opb = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (m_pend) begin
      m_age++;
      if (CE && (INP_VALID & ~m_held) != 2'b00) begin
        model_issue(m_mode, m_cmd, m_cin, 2'b11,
                    m_held[0] ? m_opa : OPA, m_held[1] ? m_opb : OPB);
        m_pend = 0;
      end else if (m_age == TO - 1) begin
        e_err = 1; m_pend = 0;
      end
    end else if (CE && INP_VALID != 2'b00) begin
      if (needs_two(MODE, CMD) && INP_VALID != 2'b11) begin
        m_pend = 1; m_age = 0; m_held = INP_VALID;
        m_mode = MODE; m_cmd = CMD; m_cin = CIN; m_opa = OPA; m_opb = OPB;
      end else begin
        model_issue(MODE, CMD, CIN, INP_VALID, OPA, OPB);
      end
    end
    e_busy = (m_busy_left > 0);
  endtask

  task automatic tick(input logic rst, input logic ce, input logic md, input logic [3:0] c,
                      input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                      input logic ci);
    RST = rst; CE = ce; MODE = md; CMD = c; INP_VALID = iv; OPA = a; OPB = b; CIN = ci;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1, 0, 0, 4'd0, 2'b00, 8'h00, 8'h00, 0);
  endtask

  task automatic test_reset();
    tick(0, 1, 1, 4'd3, 2'b11, 8'hFF, 8'hFF, 1);
    checks++;
    if ({BUSY, TIMEOUT_ERR, ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_INP_VALID, ALU_OPA, ALU_OPB} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {BUSY, TIMEOUT_ERR, ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_INP_VALID, ALU_OPA, ALU_OPB});
    end
  endtask

  task automatic test_full_issue();
    tick(1, 1, 1, 4'd0, 2'b11, 8'h12, 8'h34, 0);
    checks++;
    if ({ALU_CE, ALU_OPA, ALU_OPB, ALU_INP_VALID} !== {1'b1, 8'h12, 8'h34, 2'b11}) begin
      errors++;
      $display("FAIL full_issue: got ce=%b a=%h b=%h iv=%b expected ce=1 a=12 b=34 iv=11",
               ALU_CE, ALU_OPA, ALU_OPB, ALU_INP_VALID);
    end
    idle(1);
    checks++;
    if ({ALU_CE, ALU_OPA, ALU_OPB} !== {1'b0, 8'h12, 8'h34}) begin
      errors++;
      $display("FAIL issue_hold: got ce=%b a=%h b=%h expected ce=0 a=12 b=34", ALU_CE, ALU_OPA, ALU_OPB);
    end
  endtask

  task automatic test_split();
    tick(1, 1, 1, 4'd0, 2'b01, 8'h05, 8'h99, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, (i == 1), 1, 4'd0, 2'b01, 8'hEE, 8'h00, 0);
      checks++;
      if (ALU_CE !== 1'b0) begin
        errors++;
        $display("FAIL split_wait_ce: cycle %0d got %b expected 0", i, ALU_CE);
      end
    end
    tick(1, 1, 1, 4'd1, 2'b10, 8'h77, 8'h07, 1);
    checks++;
    if ({ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_OPA, ALU_OPB, ALU_INP_VALID} !==
        {1'b1, 1'b1, 4'd0, 1'b0, 8'h05, 8'h07, 2'b11}) begin
      errors++;
      $display("FAIL split_merge: got ce=%b md=%b cmd=%0d cin=%b a=%h b=%h iv=%b expected 1 1 0 0 05 07 11",
               ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_OPA, ALU_OPB, ALU_INP_VALID);
    end
  endtask

  task automatic test_timeout();
    int err_seen, ce_seen;
    err_seen = 0; ce_seen = 0;
    tick(1, 1, 0, 4'd0, 2'b10, 8'h00, 8'hAA, 0);
    for (int k = 1; k <= TO + 2; k++) begin
      idle(1);
      if (ALU_CE) ce_seen++;
      checks++;
      if (TIMEOUT_ERR !== (k == TO - 1)) begin
        errors++;
        $display("FAIL timeout_pulse: cycle %0d got %b expected %b", k, TIMEOUT_ERR, (k == TO - 1));
      end
      if (TIMEOUT_ERR) err_seen++;
    end
    checks++;
    if (ce_seen != 0 || err_seen != 1) begin
      errors++;
      $display("FAIL timeout_summary: got ce=%0d err=%0d expected ce=0 err=1", ce_seen, err_seen);
    end
  endtask

  task automatic test_expiry_arrival();
    tick(1, 1, 1, 4'd2, 2'b10, 8'h00, 8'h3C, 1);
    idle(TO - 2);
    tick(1, 1, 1, 4'd7, 2'b01, 8'hC3, 8'h00, 0);
    checks++;
    if ({ALU_CE, TIMEOUT_ERR, ALU_CMD, ALU_CIN, ALU_OPA, ALU_OPB, ALU_INP_VALID} !==
        {1'b1, 1'b0, 4'd2, 1'b1, 8'hC3, 8'h3C, 2'b11}) begin
      errors++;
      $display("FAIL expiry_arrival: got ce=%b err=%b cmd=%0d cin=%b a=%h b=%h iv=%b expected 1 0 2 1 c3 3c 11",
               ALU_CE, TIMEOUT_ERR, ALU_CMD, ALU_CIN, ALU_OPA, ALU_OPB, ALU_INP_VALID);
    end
    idle(1);
    checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      errors++;
      $display("FAIL expiry_no_err: got %b expected 0", TIMEOUT_ERR);
    end
  endtask

  task automatic test_mul_hold();
    tick(1, 1, 1, 4'd9, 2'b11, 8'h03, 8'h04, 0);
    checks++;
    if ({ALU_CE, BUSY} !== 2'b11) begin
      errors++;
      $display("FAIL mul_issue: got ce=%b busy=%b expected 1 1", ALU_CE, BUSY);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(1, 1, 1, 4'd4, 2'b01, 8'(8'h40 + k), 8'h00, 0);
      checks++;
      if ({BUSY, ALU_CE} !== {(k < GAP), (k == GAP + 1)}) begin
        errors++;
        $display("FAIL mul_hold: cycle %0d got busy=%b ce=%b expected busy=%b ce=%b",
                 k, BUSY, ALU_CE, (k < GAP), (k == GAP + 1));
      end
    end
    checks++;
    if ({ALU_CMD, ALU_OPA} !== {4'd4, 8'h44}) begin
      errors++;
      $display("FAIL mul_after: got cmd=%0d a=%h expected 4 44", ALU_CMD, ALU_OPA);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 1, 0, 4'd5, 2'b01, 8'h11, 8'h00, 0);
    idle(3);
    tick(0, 0, 0, 4'd0, 2'b00, 8'h00, 8'h00, 0);
    checks++;
    if ({BUSY, TIMEOUT_ERR, ALU_CE, ALU_OPA, ALU_OPB, ALU_INP_VALID} !== 21'd0) begin
      errors++;
      $display("FAIL reset_wait: got busy=%b err=%b ce=%b a=%h b=%h iv=%b expected all 0",
               BUSY, TIMEOUT_ERR, ALU_CE, ALU_OPA, ALU_OPB, ALU_INP_VALID);
    end
    for (int k = 0; k < TO + 2; k++) begin
      idle(1);
      checks++;
      if (TIMEOUT_ERR !== 1'b0) begin
        errors++;
        $display("FAIL reset_drop_err: cycle %0d got %b expected 0", k, TIMEOUT_ERR);
      end
    end
    tick(1, 1, 1, 4'd10, 2'b11, 8'h0F, 8'hF0, 1);
    idle(1);
    tick(0, 1, 1, 4'd1, 2'b11, 8'h55, 8'h55, 0);
    checks++;
    if ({BUSY, ALU_CE, ALU_MODE, ALU_CMD, ALU_OPA} !== 15'd0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b ce=%b md=%b cmd=%0d a=%h expected all 0",
               BUSY, ALU_CE, ALU_MODE, ALU_CMD, ALU_OPA);
    end
    tick(1, 1, 1, 4'd4, 2'b01, 8'h66, 8'h00, 0);
    checks++;
    if ({ALU_CE, ALU_CMD, ALU_INP_VALID, ALU_OPA} !== {1'b1, 4'd4, 2'b01, 8'h66}) begin
      errors++;
      $display("FAIL reset_then_issue: got ce=%b cmd=%0d iv=%b a=%h expected 1 4 01 66",
               ALU_CE, ALU_CMD, ALU_INP_VALID, ALU_OPA);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      tick(1, 1, 0, 4'd6, 2'b01, 8'(k * 3), 8'h00, 0);
      checks++;
      if ({ALU_CE, ALU_OPA} !== {1'b1, 8'(k * 3)}) begin
        errors++;
        $display("FAIL back_to_back: cycle %0d got ce=%b a=%h expected 1 %h", k, ALU_CE, ALU_OPA, 8'(k * 3));
      end
    end
  endtask

  task automatic test_random();
    bit sparse;
    for (int k = 0; k < 800; k++) begin
      sparse = ((k / 64) % 2) == 1;
      tick($urandom_range(0, 149) != 0,
           sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0),
           1'($urandom), 4'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      checks++;
      if ({BUSY, TIMEOUT_ERR, ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_INP_VALID, ALU_OPA, ALU_OPB} !==
          {e_busy, e_err, e_ce, e_mode, e_cmd, e_cin, e_iv, e_opa, e_opb}) begin
        errors++;
        $display("FAIL random_cycle %0d: got busy=%b err=%b ce=%b md=%b cmd=%0d cin=%b iv=%b a=%h b=%h expected busy=%b err=%b ce=%b md=%b cmd=%0d cin=%b iv=%b a=%h b=%h",
                 k, BUSY, TIMEOUT_ERR, ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_INP_VALID, ALU_OPA, ALU_OPB,
                 e_busy, e_err, e_ce, e_mode, e_cmd, e_cin, e_iv, e_opa, e_opb);
      end
    end
  endtask

  initial begin
    RST = 0; CE = 0; MODE = 0; CMD = 0; INP_VALID = 0; OPA = 0; OPB = 0; CIN = 0;
    test_reset();
    test_full_issue();
    test_split();
    test_timeout();
    test_expiry_arrival();
    test_mul_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
